// File: rtl/nlc_sample_buffer_if.sv
// Bundle between the ADC/engine side and the sample buffer.
// Handshake: srdyi and nlc_done are single-cycle qualifiers with no back-pressure. srdyo is a
// one-cycle issue pulse; x_adc is valid from that cycle until the next issue.
interface nlc_sample_buffer_if #(
    parameter int WIDTH      = 21,
    parameter int DEPTH_LOG2 = 4
);
    logic                  srdyi;
    logic [WIDTH-1:0]      x_in;
    logic                  clr_status;
    logic                  nlc_done;
    logic                  srdyo;
    logic [WIDTH-1:0]      x_adc;
    logic                  busy;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  overflow;
    logic [15:0]           drop_count;
    logic                  timeout_flag;

    modport master (
        output srdyi, x_in, clr_status, nlc_done,
        input  srdyo, x_adc, busy, fifo_count, overflow, drop_count, timeout_flag
    );

    modport slave (
        input  srdyi, x_in, clr_status, nlc_done,
        output srdyo, x_adc, busy, fifo_count, overflow, drop_count, timeout_flag
    );
endinterface

// File: rtl/nlc_sample_buffer.sv
// Sample FIFO ahead of the NLC engine: issues one sample at a time and waits for completion,
// with drop accounting and a watchdog that abandons a run the engine never finishes.
module nlc_sample_buffer #(
    parameter int WIDTH      = 21,
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    nlc_sample_buffer_if.slave   bus,
    output logic [1:0]           dbg_state_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [15:0]           WDOG_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [WIDTH-1:0]      x_adc_q, x_adc_d;
    logic [15:0]           wdog_q, wdog_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           drop_q, drop_d;
    logic                  tmo_q, tmo_d;
    logic                  tmo_set;
    logic                  pop, push, drop, full;
    logic [WIDTH-1:0]      mem_q [DEPTH];

    // The ISSUE pop frees a slot in the same edge, so a full FIFO still accepts a sample then.
    assign pop  = (state_q == ISSUE);
    assign full = (count_q == CNT_FULL);
    assign push = bus.srdyi && (!full || pop);
    assign drop = bus.srdyi && full && !pop;

    always_comb begin
        state_d = state_q;
        x_adc_d = x_adc_q;
        wdog_d  = wdog_q;
        tmo_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = ISSUE;
                    x_adc_d = mem_q[rd_ptr_q];
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wdog_d  = '0;
            end
            WAIT: begin
                if (bus.nlc_done) begin
                    state_d = IDLE;
                    wdog_d  = '0;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = IDLE;
                    tmo_set = 1'b1;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // A clear in the same cycle as a new drop or timeout wins.
    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        tmo_d      = tmo_q;
        if (bus.clr_status) begin
            overflow_d = 1'b0;
            drop_d     = '0;
            tmo_d      = 1'b0;
        end else begin
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
            if (tmo_set) begin
                tmo_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            x_adc_q    <= '0;
            wdog_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            x_adc_q    <= x_adc_d;
            wdog_q     <= wdog_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            tmo_q      <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.x_in;
        end
    end

    assign bus.srdyo        = (state_q == ISSUE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.x_adc        = x_adc_q;
    assign bus.fifo_count   = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.drop_count   = drop_q;
    assign bus.timeout_flag = tmo_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_nlc_sample_buffer.sv
// Self-checking bench for nlc_sample_buffer: directed scenarios plus a randomized phase, all
// checked every cycle against a queue-based reference of the buffer's rules.
module tb_nlc_sample_buffer;
    localparam int W     = 21;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    nlc_sample_buffer_if #(.WIDTH(W), .DEPTH_LOG2(DL)) bus ();

    nlc_sample_buffer #(.WIDTH(W), .DEPTH_LOG2(DL), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Reference: exp_q holds buffered samples in arrival order; the engine run is tracked as
    // "issuing this cycle" or "waiting for <age> cycles".
    logic [W-1:0] exp_q[$];
    bit           m_issuing;
    bit           m_waiting;
    int           m_age;
    logic [W-1:0] m_x;
    bit           m_ovf;
    bit           m_tmo;
    int           m_drops;

    logic [W-1:0] src_q[$];
    logic [W-1:0] issued_log[$];
    int           gap_pct, spur_pct, eng_lo, eng_hi, eng_at;
    bit           clr_req;
    int           cyc, last_issue_cyc;
    int           n_checks = 0;
    int           n_fail = 0;
    int           s1, s2;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic check_all();
        check_val("srdyo",        32'(bus.srdyo),        32'(m_issuing));
        check_val("busy",         32'(bus.busy),         32'(m_issuing || m_waiting));
        check_val("fifo_count",   32'(bus.fifo_count),   32'(exp_q.size()));
        check_val("x_adc",        32'(bus.x_adc),        32'(m_x));
        check_val("overflow",     32'(bus.overflow),     32'(m_ovf));
        check_val("drop_count",   32'(bus.drop_count),   32'(m_drops));
        check_val("timeout_flag", 32'(bus.timeout_flag), 32'(m_tmo));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_issuing = 1'b0;
        m_waiting = 1'b0;
        m_age     = 0;
        m_x       = '0;
        m_ovf     = 1'b0;
        m_tmo     = 1'b0;
        m_drops   = 0;
    endtask

    task automatic model_step(input bit s, input logic [W-1:0] x, input bit c, input bit d);
        bit was_issuing;
        bit dropped;
        bit timed_out;
        int size_before;
        was_issuing = m_issuing;
        dropped     = 1'b0;
        timed_out   = 1'b0;
        size_before = exp_q.size();
        if (m_issuing) begin
            m_issuing = 1'b0;
            m_waiting = 1'b1;
            m_age     = 0;
        end else if (m_waiting) begin
            if (d) m_waiting = 1'b0;
            else if (m_age == TMO - 1) begin
                m_waiting = 1'b0;
                timed_out = 1'b1;
            end else m_age++;
        end else if (size_before > 0) begin
            m_issuing = 1'b1;
            m_x       = exp_q[0];
        end
        if (was_issuing) void'(exp_q.pop_front());
        if (s) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(x);
            else dropped = 1'b1;
        end
        if (c) begin
            m_ovf   = 1'b0;
            m_drops = 0;
            m_tmo   = 1'b0;
        end else begin
            if (dropped) begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
            if (timed_out) m_tmo = 1'b1;
        end
    endtask

    // Drives the inputs for cycle cyc, advances one edge, then checks the new cycle.
    task automatic tick();
        bit           s, c, d;
        logic [W-1:0] x;
        s = (src_q.size() > 0) && ($urandom_range(99) >= gap_pct);
        x = s ? src_q.pop_front() : W'($urandom);
        c = clr_req;
        clr_req = 1'b0;
        d = (cyc == eng_at) || ($urandom_range(99) < spur_pct);
        bus.srdyi      = s;
        bus.x_in       = x;
        bus.clr_status = c;
        bus.nlc_done   = d;
        @(posedge clk);
        model_step(s, x, c, d);
        cyc++;
        #1;
        check_all();
        if (m_issuing) begin
            issued_log.push_back(m_x);
            last_issue_cyc = cyc;
            if (eng_hi > 0) eng_at = cyc + int'($urandom_range(eng_hi, eng_lo));
        end
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, releases away from the edge.
    task automatic do_reset();
        #3;
        reset = 1'b1;
        bus.srdyi = 1'b0; bus.x_in = '0; bus.clr_status = 1'b0; bus.nlc_done = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0; eng_at = -1; last_issue_cyc = -1;
        gap_pct = 0; spur_pct = 0; eng_lo = 1; eng_hi = 0; clr_req = 1'b0;
        src_q.delete();
        issued_log.delete();
    endtask

    initial begin
        bus.srdyi = 1'b0; bus.x_in = '0; bus.clr_status = 1'b0; bus.nlc_done = 1'b0;
        @(posedge clk);
        #1;

        // Single sample with a fixed engine latency.
        do_reset();
        repeat (5) tick();
        src_q.push_back(21'h0ABCD);
        eng_lo = 13; eng_hi = 13;
        while (cyc < 21) tick();
        check_val("t1_issue_cyc", 32'(last_issue_cyc), 32'd7);
        check_val("t1_issue_val", 32'(issued_log.size() > 0 ? issued_log[0] : '0), 32'h0ABCD);
        check_val("t1_busy21", 32'(bus.busy), 32'd0);
        check_val("t1_cnt21", 32'(bus.fifo_count), 32'd0);

        // Burst of 16 with a 10-cycle engine.
        do_reset();
        for (int i = 1; i <= 16; i++) src_q.push_back(W'(i));
        eng_lo = 10; eng_hi = 10;
        for (int i = 0; i < 400 && (src_q.size() > 0 || exp_q.size() > 0 || m_issuing || m_waiting); i++) tick();
        check_val("t2_drained", 32'(bus.busy), 32'd0);
        check_val("t2_n_issued", 32'(issued_log.size()), 32'd16);
        for (int i = 0; i < issued_log.size(); i++) check_val("t2_order", 32'(issued_log[i]), 32'(i + 1));
        check_val("t2_overflow", 32'(bus.overflow), 32'd0);

        // Overflow with a silent engine, then clear (also against a same-cycle drop).
        do_reset();
        for (int i = 0; i < 20; i++) src_q.push_back(W'(100 + i));
        while (cyc < 20) tick();
        check_val("t3_drops", 32'(bus.drop_count), 32'd3);
        check_val("t3_ovf", 32'(bus.overflow), 32'd1);
        check_val("t3_cnt", 32'(bus.fifo_count), 32'd16);
        check_val("t3_n_issued", 32'(issued_log.size()), 32'd1);
        clr_req = 1'b1;
        tick();
        check_val("t3_clr_ovf", 32'(bus.overflow), 32'd0);
        check_val("t3_clr_drops", 32'(bus.drop_count), 32'd0);
        src_q.push_back(21'h1F00F);
        clr_req = 1'b1;
        tick();
        check_val("t3_clr_wins", 32'(bus.overflow), 32'd0);

        // Full FIFO: a sample arriving in the ISSUE cycle is accepted.
        for (int i = 0; i < 100 && (m_issuing || m_waiting); i++) tick();
        check_val("t4_idle_full", 32'(bus.fifo_count), 32'd16);
        tick();
        check_val("t4_issue", 32'(bus.srdyo), 32'd1);
        check_val("t4_issue_val", 32'(bus.x_adc), 32'd101);
        src_q.push_back(21'h15555);
        tick();
        check_val("t4_cnt_kept", 32'(bus.fifo_count), 32'd16);
        check_val("t4_no_drop", 32'(bus.drop_count), 32'd0);

        // Watchdog abort, then a completion on the last WAIT cycle beating the watchdog.
        do_reset();
        src_q.push_back(21'h11111);
        src_q.push_back(21'h22222);
        for (int i = 0; i < 20 && last_issue_cyc < 0; i++) tick();
        s1 = last_issue_cyc;
        check_val("t5_first_issue", 32'(s1), 32'd2);
        for (int i = 0; i < 100 && cyc < s1 + TMO; i++) tick();
        check_val("t5_last_wait", 32'(bus.busy), 32'd1);
        tick();
        check_val("t5_abort_idle", 32'(bus.busy), 32'd0);
        check_val("t5_flag", 32'(bus.timeout_flag), 32'd1);
        tick();
        check_val("t5_next_issue", 32'(bus.srdyo), 32'd1);
        check_val("t5_next_val", 32'(bus.x_adc), 32'h22222);
        s2 = cyc;
        clr_req = 1'b1;
        eng_at = s2 + TMO;
        for (int i = 0; i < 100 && cyc < s2 + TMO + 1; i++) tick();
        check_val("t5_done_wins_idle", 32'(bus.busy), 32'd0);
        check_val("t5_done_wins_flag", 32'(bus.timeout_flag), 32'd0);

        // Async reset in the middle of a WAIT with samples queued.
        do_reset();
        for (int i = 0; i < 6; i++) src_q.push_back(W'(32'h300 + i));
        for (int i = 0; i < 30 && !(m_waiting && exp_q.size() == 5); i++) tick();
        check_val("t6_queued", 32'(bus.fifo_count), 32'd5);
        do_reset();
        check_val("t6_cnt", 32'(bus.fifo_count), 32'd0);
        repeat (10) tick();
        check_val("t6_no_issue", 32'(issued_log.size()), 32'd0);

        // Randomized traffic: bursts, slow or dead engine runs, stray completions, clears.
        do_reset();
        eng_lo = 1; eng_hi = 26; spur_pct = 3;
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 0) gap_pct = int'($urandom_range(70, 0));
            if (src_q.size() < 3) src_q.push_back(W'($urandom));
            if ($urandom_range(99) < 2) clr_req = 1'b1;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
